// File: rtl/mem_pipe_sp.sv
// Parametrised single-port synchronous memory with byte-lane write strobes,
// a configurable read-latency pipeline, self-initialisation after reset and
// error reporting for illegal or out-of-range requests.
module mem_pipe_sp #(
  parameter int unsigned        ADDR_W   = 3,
  parameter int unsigned        DATA_W   = 8,
  parameter int unsigned        DEPTH    = 8,
  parameter int unsigned        RD_LAT   = 1,
  parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     addr,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  output logic [DATA_W-1:0]     rdata,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  err
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                busy_d;
  logic                err_d;

  logic                mem_we;
  logic [NB-1:0]       mem_be;
  logic [IDX_W-1:0]    mem_idx;
  logic [DATA_W-1:0]   mem_wd;
  logic                rd_acc;
  logic                in_range;
  logic [DATA_W-1:0]   rd_data_c;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                pv_q [RD_LAT];
  logic [DATA_W-1:0]   pd_q [RD_LAT];

  // Address range check; a fully populated address space is always in range
  if (DEPTH >= (1 << ADDR_W)) begin : g_full
    assign in_range = 1'b1;
  end else begin : g_part
    assign in_range = (addr < ADDR_W'(DEPTH));
  end

  // Read port: out-of-range reads return zero
  assign rd_data_c = in_range ? mem[IDX_W'(addr)] : '0;

  // Next-state, init sequencing, request decode and memory write control
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy;
    err_d   = 1'b0;
    mem_we  = 1'b0;
    mem_be  = '0;
    mem_idx = IDX_W'(addr);
    mem_wd  = wdata;
    rd_acc  = 1'b0;

    case (state_q)
      ST_INIT: begin
        busy_d  = 1'b1;
        mem_we  = 1'b1;
        mem_be  = '1;
        mem_idx = IDX_W'(cnt_q);
        mem_wd  = INIT_VAL;
        err_d   = wr_en | rd_en;
        if (cnt_q == LAST) begin
          state_d = ST_READY;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      ST_READY: begin
        busy_d = 1'b0;
        err_d  = (wr_en | rd_en) & ~in_range;
        rd_acc = rd_en;
        if (wr_en && in_range) begin
          mem_we = 1'b1;
          mem_be = wstrb;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase

    if (reset) begin
      mem_we = 1'b0;
      rd_acc = 1'b0;
    end
  end

  // State, init counter and status flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      busy    <= 1'b1;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy    <= busy_d;
      err     <= err_d;
    end
  end

  // Storage array; only init writes and accepted writes modify it
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_be[i]) begin
          mem[mem_idx][8*i +: 8] <= mem_wd[8*i +: 8];
        end
      end
    end
  end

  // Read pipeline; idle stages carry zero so rdata is 0 whenever not valid
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pv_q[i] <= 1'b0;
        pd_q[i] <= '0;
      end
    end else begin
      pv_q[0] <= rd_acc;
      pd_q[0] <= rd_acc ? rd_data_c : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pd_q[i] <= pd_q[i-1];
      end
    end
  end

  assign rdata    = pd_q[RD_LAT-1];
  assign rd_valid = pv_q[RD_LAT-1];

endmodule

// File: tb/tb_mem_pipe_sp.sv
// Bench for mem_pipe_sp: directed vector table plus randomized traffic,
// both checked every cycle against a queue-based reference model.
module tb_mem_pipe_sp;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 6;
  localparam int unsigned RD_LAT = 3;
  localparam logic [31:0] INIT_VAL = 32'hA5A5_0F0F;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [2:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic [31:0] rdata;
  logic        rd_valid;
  logic        busy;
  logic        err;

  always #5 clk = ~clk;

  mem_pipe_sp #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .RD_LAT   (RD_LAT),
    .INIT_VAL (INIT_VAL)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .rdata    (rdata),
    .rd_valid (rd_valid),
    .busy     (busy),
    .err      (err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: reads are scheduled by due cycle in a queue; memory is
  // a plain array filled with INIT_VAL once the init period has elapsed.
  typedef struct {
    longint      due;
    logic [31:0] data;
  } rd_t;

  rd_t         rq[$];
  logic [31:0] mm [DEPTH];
  int          init_left = 0;
  longint      t = 0;
  bit          model_on = 0;
  logic [31:0] e_rdata = '0;
  logic        e_valid = 1'b0;
  logic        e_busy = 1'b1;
  logic        e_err = 1'b0;

  always @(posedge clk) begin
    bit ok;
    t++;
    e_err = 1'b0;
    if (reset) begin
      model_on  = 1;
      rq.delete();
      init_left = DEPTH;
      e_busy    = 1'b1;
    end else if (model_on) begin
      if (init_left > 0) begin
        e_err = wr_en | rd_en;
        init_left--;
        if (init_left == 0)
          foreach (mm[i]) mm[i] = INIT_VAL;
      end else begin
        ok    = int'(addr) < int'(DEPTH);
        e_err = (wr_en | rd_en) && !ok;
        if (rd_en)
          rq.push_back('{t + RD_LAT - 1, ok ? mm[addr] : 32'h0});
        if (wr_en && ok)
          for (int b = 0; b < 4; b++)
            if (wstrb[b]) mm[addr][8*b +: 8] = wdata[8*b +: 8];
      end
      e_busy = (init_left != 0);
    end
    e_valid = 1'b0;
    e_rdata = '0;
    if (rq.size() > 0 && rq[0].due == t) begin
      e_valid = 1'b1;
      e_rdata = rq[0].data;
      void'(rq.pop_front());
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (model_on) begin
      check("model_rd_valid", 32'(rd_valid), 32'(e_valid));
      check("model_rdata",    rdata,         e_rdata);
      check("model_busy",     32'(busy),     32'(e_busy));
      check("model_err",      32'(err),      32'(e_err));
    end
  end

  typedef struct {
    logic        rst;
    logic        we;
    logic        re;
    logic [2:0]  a;
    logic [31:0] wd;
    logic [3:0]  st;
    logic        ev;
    logic [31:0] ed;
    logic        ee;
    logic        eb;
  } vec_t;

  vec_t tv[$];

  initial begin
    // {rst, we, re, addr, wdata, wstrb, exp_valid, exp_rdata, exp_err, exp_busy}
    tv.push_back('{1, 0, 0, 0, 32'h0,         4'h0, 0, 32'h0,         0, 1}); // reset
    tv.push_back('{0, 0, 0, 0, 32'h0,         4'h0, 0, 32'h0,         0, 1});
    tv.push_back('{0, 0, 1, 0, 32'h0,         4'h0, 0, 32'h0,         1, 1}); // read while busy
    tv.push_back('{0, 1, 0, 1, 32'hFFFF_FFFF, 4'hF, 0, 32'h0,         1, 1}); // write while busy
    tv.push_back('{0, 0, 0, 0, 32'h0,         4'h0, 0, 32'h0,         0, 1});
    tv.push_back('{0, 0, 0, 0, 32'h0,         4'h0, 0, 32'h0,         0, 1});
    tv.push_back('{0, 0, 0, 0, 32'h0,         4'h0, 0, 32'h0,         0, 0}); // busy falls
    tv.push_back('{0, 0, 1, 1, 32'h0,         4'h0, 0, 32'h0,         0, 0}); // rd 1
    tv.push_back('{0, 1, 0, 2, 32'h1122_3344, 4'hF, 0, 32'h0,         0, 0});
    tv.push_back('{0, 1, 0, 2, 32'hAABB_CCDD, 4'h5, 1, 32'hA5A5_0F0F, 0, 0});
    tv.push_back('{0, 0, 1, 2, 32'h0,         4'h0, 0, 32'h0,         0, 0}); // rd 2
    tv.push_back('{0, 1, 0, 1, 32'h0000_003C, 4'hF, 0, 32'h0,         0, 0});
    tv.push_back('{0, 1, 1, 1, 32'h0000_007E, 4'hF, 1, 32'h11BB_33DD, 0, 0}); // RBW
    tv.push_back('{0, 0, 1, 1, 32'h0,         4'h0, 0, 32'h0,         0, 0});
    tv.push_back('{0, 1, 0, 7, 32'h0000_00FF, 4'hF, 1, 32'h0000_003C, 1, 0}); // OOR wr
    tv.push_back('{0, 0, 1, 7, 32'h0,         4'h0, 1, 32'h0000_007E, 1, 0}); // OOR rd
    tv.push_back('{0, 1, 1, 6, 32'h0000_00FF, 4'hF, 0, 32'h0,         1, 0}); // OOR both
    tv.push_back('{0, 0, 0, 0, 32'h0,         4'h0, 1, 32'h0,         0, 0});
    tv.push_back('{0, 1, 0, 3, 32'h1234_5678, 4'h0, 1, 32'h0,         0, 0}); // strobe 0
    tv.push_back('{0, 0, 1, 3, 32'h0,         4'h0, 0, 32'h0,         0, 0});
    tv.push_back('{0, 0, 1, 3, 32'h0,         4'h0, 0, 32'h0,         0, 0});
    tv.push_back('{0, 0, 1, 3, 32'h0,         4'h0, 1, 32'hA5A5_0F0F, 0, 0});
    tv.push_back('{0, 0, 0, 0, 32'h0,         4'h0, 1, 32'hA5A5_0F0F, 0, 0});
    tv.push_back('{0, 0, 0, 0, 32'h0,         4'h0, 1, 32'hA5A5_0F0F, 0, 0});
    tv.push_back('{0, 0, 1, 0, 32'h0,         4'h0, 0, 32'h0,         0, 0}); // in-flight
    tv.push_back('{0, 0, 1, 1, 32'h0,         4'h0, 0, 32'h0,         0, 0}); // in-flight
    tv.push_back('{1, 0, 0, 0, 32'h0,         4'h0, 0, 32'h0,         0, 1}); // reset mid-op
    tv.push_back('{0, 0, 0, 0, 32'h0,         4'h0, 0, 32'h0,         0, 1});
    tv.push_back('{0, 0, 0, 0, 32'h0,         4'h0, 0, 32'h0,         0, 1});
    tv.push_back('{1, 0, 0, 0, 32'h0,         4'h0, 0, 32'h0,         0, 1}); // reset in INIT
    for (int i = 0; i < 5; i++)
      tv.push_back('{0, 0, 0, 0, 32'h0,       4'h0, 0, 32'h0,         0, 1});
    tv.push_back('{0, 0, 0, 0, 32'h0,         4'h0, 0, 32'h0,         0, 0}); // busy falls
    tv.push_back('{0, 0, 1, 2, 32'h0,         4'h0, 0, 32'h0,         0, 0});
    tv.push_back('{0, 0, 1, 1, 32'h0,         4'h0, 0, 32'h0,         0, 0});
    tv.push_back('{0, 0, 0, 0, 32'h0,         4'h0, 1, 32'hA5A5_0F0F, 0, 0}); // re-init
    tv.push_back('{0, 0, 0, 0, 32'h0,         4'h0, 1, 32'hA5A5_0F0F, 0, 0});
    tv.push_back('{0, 0, 0, 0, 32'h0,         4'h0, 0, 32'h0,         0, 0});

    // Directed table
    for (int i = 0; i < tv.size(); i++) begin
      reset = tv[i].rst;
      wr_en = tv[i].we;
      rd_en = tv[i].re;
      addr  = tv[i].a;
      wdata = tv[i].wd;
      wstrb = tv[i].st;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_rd_valid", i), 32'(rd_valid), 32'(tv[i].ev));
      check($sformatf("vec%0d_rdata", i),    rdata,         tv[i].ed);
      check($sformatf("vec%0d_err", i),      32'(err),      32'(tv[i].ee));
      check($sformatf("vec%0d_busy", i),     32'(busy),     32'(tv[i].eb));
    end

    // Randomized traffic with occasional resets, checked by the model
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      wr_en = ($urandom_range(0, 2) == 0);
      rd_en = ($urandom_range(0, 1) == 0);
      addr  = 3'($urandom_range(0, 7));
      wdata = $urandom;
      wstrb = 4'($urandom_range(0, 15));
      @(posedge clk);
      @(negedge clk);
    end

    reset = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    repeat (RD_LAT + 2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_pipe_sp.md
Name: mem_pipe_sp

Overview:
- Parametrised single-port synchronous memory; successor to the fixed 8-location by 8-bit memory model.
- Adds configurable width and depth, byte-lane write strobes and a configurable read-latency pipeline with a read-valid flag.
- Adds hardware self-initialisation after reset and out-of-range/illegal-access error reporting.
- Sits behind the memory interface as the DUT driven by the UVM driver and observed by the monitor.

Parameters:
- ADDR_W, 3, address width in bits.
- DATA_W, 8, data width in bits; must be a multiple of 8.
- DEPTH, 8, number of words. Must satisfy DEPTH <= 2**ADDR_W.
- RD_LAT, 1, read latency in cycles, legal range 1..4.
- INIT_VAL, 0, value written to every word during initialisation (DATA_W bits).

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- addr  input  ADDR_W  word address.
- wr_en  input  1  write request.
- rd_en  input  1  read request.
- wdata  input  DATA_W  write data.
- wstrb  input  DATA_W/8  byte-lane write enables; bit i covers wdata[8i+7:8i].
- rdata  output  DATA_W  read data.
- rd_valid  output  1  rdata valid this cycle.
- busy  output  1  initialisation in progress; requests are not accepted.
- err  output  1  one-cycle error pulse.

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high.
- Reset values, applied on the clock edge where reset=1:
  - rdata=0, rd_valid=0, err=0, busy=1.
  - Read pipeline flushed; init counter=0; FSM enters INIT.
- FSM states:
  - INIT: each cycle writes INIT_VAL to mem[cnt] and increments cnt. When the write to cnt=DEPTH-1 completes, go to READY; busy falls in that same transition, so busy=1 for exactly DEPTH cycles after reset deasserts.
  - READY: services requests. Stays in READY until reset.
- Requests in INIT: wr_en or rd_en sampled while busy=1 is ignored. Memory is unaffected, no rd_valid is produced, and err pulses the next cycle.
- Write (READY, wr_en=1, addr<DEPTH): on the sampling edge, byte lanes with wstrb[i]=1 are updated; the other lanes keep their value. wstrb=0 is a legal no-op with no error.
- Read (READY, rd_en=1): rdata and rd_valid=1 appear exactly RD_LAT cycles after the sampling edge.
  - RD_LAT=1 means valid on the cycle after the request.
  - The pipeline accepts one read per cycle; back-to-back reads give back-to-back rd_valid.
- rdata when rd_valid=0: holds 0.
- Simultaneous wr_en and rd_en to the same address: read-before-write. The read returns the pre-write contents and the write still commits.
- Out-of-range address (addr>=DEPTH) in READY:
  - Write is dropped.
  - Read still produces rd_valid after RD_LAT cycles, with rdata=0.
  - err pulses 1 cycle after the sampling edge. It is one pulse per request cycle, even if both wr_en and rd_en are set.
- err is not sticky. Consecutive bad cycles give consecutive err=1.
- Reset mid-operation:
  - In-flight reads are discarded; no rd_valid emerges after reset.
  - Memory is re-initialised to INIT_VAL.
  - A reset asserted during INIT restarts cnt at 0.
- Memory contents are never reset directly; they are only written by INIT or by accepted writes.
- No combinational path from inputs to outputs.

Test Plan:
- Init sequence: deassert reset, hold wr_en=rd_en=0.
  - busy=1 for 8 cycles, then 0.
  - Then read all addresses 0..7; each gives rd_valid with rdata=0x00 at RD_LAT=1.
- Write/read: write addr=5, wdata=0xA5, wstrb=1.
  - Read addr=5 next cycle gives rdata=0xA5, rd_valid=1 one cycle after rd_en.
  - Back-to-back reads of 5,5,5 give three consecutive valid cycles.
- Byte strobes (DATA_W=32): write addr=2 data 0x11223344 wstrb=0xF, then data 0xAABBCCDD wstrb=0x5.
  - Read addr=2 gives 0x11BB33DD.
- Read-before-write and latency (RD_LAT=3): addr=1 holds 0x3C; same cycle wr_en=rd_en=1, addr=1, wdata=0x7E.
  - rdata=0x3C with rd_valid exactly 3 cycles later.
  - A subsequent read returns 0x7E.
- Errors (DEPTH=6): write addr=7 data 0xFF, then read addr=7.
  - err pulses 1 cycle after each request.
  - Read gives rd_valid with rdata=0.
  - Request during busy=1 gives err and no rd_valid.
- Reset mid-op (RD_LAT=4): issue reads of addr 0..2 on three consecutive cycles, then assert reset one cycle later.
  - No rd_valid emerges.
  - busy returns to 1; after re-init, previously written locations read INIT_VAL.
